// File: rtl/midi_pkg.sv
// Shared encodings for the MIDI front panel: LED FSM states,
// button event codes and MIDI receiver states.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam logic [1:0] BTN_NONE = 2'd0;
    localparam logic [1:0] BTN1     = 2'd1;
    localparam logic [1:0] BTN2     = 2'd2;
    localparam logic [1:0] BTN_IGN  = 2'd3;

    localparam logic [1:0] MIDI_IDLE  = 2'd0;
    localparam logic [1:0] MIDI_ARMED = 2'd1;

    function automatic logic is_btn(input logic [1:0] b);
        return (b == BTN1) || (b == BTN2);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Phase timer: counts cycles since clear and pulses done on the
// last cycle of a phase of 'length' cycles, then restarts from 0.
module blink_timer #(
    parameter int MAX_LEN = 4,
    localparam int CW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [LW-1:0] length,
    output logic          done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done = (LW'(cnt_q) == (length - LW'(1)));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_feedback.sv
// Indicator LED driver: slow blinks for recall, fast blinks for save,
// and mirrors the MIDI armed state while idle.
module led_feedback
    import midi_pkg::*;
#(
    parameter int PHASE_CNT   = 2700000,
    parameter int FAST_DIV    = 4,
    parameter int SAVE_BLINKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_index,
    input  logic       save_mode,
    input  logic [1:0] midi_in_state,
    output logic       led,
    output logic       busy,
    output logic [1:0] last_index
);

    localparam int LW = $clog2(PHASE_CNT + 1);
    localparam logic [LW-1:0] SLOW_LEN = LW'(PHASE_CNT);
    localparam logic [LW-1:0] FAST_LEN = LW'(PHASE_CNT / FAST_DIV);
    localparam logic [3:0]    SAVE_N   = 4'(SAVE_BLINKS);

    state_e     state_q, state_d;
    logic [3:0] blinks_q, blinks_d;
    logic       save_q, save_d;
    logic       led_q, led_d;
    logic       busy_q, busy_d;
    logic [1:0] last_q, last_d;

    logic          evt;
    logic          done;
    logic          tmr_clear;
    logic [LW-1:0] tmr_len;

    assign evt       = is_btn(btn_index);
    assign tmr_clear = evt || (state_q == ST_IDLE);
    assign tmr_len   = save_q ? FAST_LEN : SLOW_LEN;

    blink_timer #(
        .MAX_LEN(PHASE_CNT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .length (tmr_len),
        .done   (done)
    );

    always_comb begin
        state_d  = state_q;
        blinks_d = blinks_q;
        save_d   = save_q;
        last_d   = last_q;
        // A new event restarts the sequence and beats terminal count.
        if (evt) begin
            state_d  = ST_ON;
            blinks_d = save_mode ? SAVE_N : {2'b00, btn_index};
            save_d   = save_mode;
            last_d   = btn_index;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (done) state_d = ST_OFF;
                end
                ST_OFF: begin
                    if (done) begin
                        if (blinks_q > 4'd1) begin
                            state_d  = ST_ON;
                            blinks_d = blinks_q - 4'd1;
                        end else begin
                            state_d  = ST_IDLE;
                            blinks_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
        led_d  = (state_d == ST_ON) ||
                 ((state_d == ST_IDLE) &&
                  (midi_in_state == MIDI_ARMED));
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            blinks_q <= '0;
            save_q   <= 1'b0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= BTN_NONE;
        end else begin
            state_q  <= state_d;
            blinks_q <= blinks_d;
            save_q   <= save_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign led        = led_q;
    assign busy       = busy_q;
    assign last_index = last_q;

endmodule

// File: tb/tb_led_feedback.sv
// Randomized scoreboard bench for led_feedback against a waveform-list
// reference model (PHASE_CNT=4, FAST_DIV=2, SAVE_BLINKS=4).
module tb_led_feedback;

    localparam int P  = 4;
    localparam int FD = 2;
    localparam int SB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_index = 2'd0;
    logic       save_mode = 1'b0;
    logic [1:0] midi_in_state = 2'd0;
    logic       led;
    logic       busy;
    logic [1:0] last_index;

    always #5 clk = ~clk;

    led_feedback #(
        .PHASE_CNT   (P),
        .FAST_DIV    (FD),
        .SAVE_BLINKS (SB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_index     (btn_index),
        .save_mode     (save_mode),
        .midi_in_state (midi_in_state),
        .led           (led),
        .busy          (busy),
        .last_index    (last_index)
    );

    logic [3:0] exp_q[$];
    bit         wave[$];
    logic [1:0] m_last = 2'd0;
    int         compared = 0;
    int         mismatched = 0;

    // Model: a pending list of LED values, one per upcoming cycle.
    task automatic step(input logic r, input logic [1:0] b,
                        input logic s, input logic [1:0] m);
        logic le;
        logic be;
        int   n;
        int   len;
        @(negedge clk);
        rst = r;
        btn_index = b;
        save_mode = s;
        midi_in_state = m;
        le = 1'b0;
        be = 1'b0;
        if (r) begin
            wave.delete();
            m_last = 2'd0;
        end else begin
            if (b == 2'd1 || b == 2'd2) begin
                m_last = b;
                wave.delete();
                n   = s ? SB : int'(b);
                len = s ? (P / FD) : P;
                for (int k = 0; k < n; k++) begin
                    repeat (len) wave.push_back(1'b1);
                    repeat (len) wave.push_back(1'b0);
                end
            end
            if (wave.size() > 0) begin
                le = wave.pop_front();
                be = 1'b1;
            end else begin
                le = (m == 2'd1);
            end
        end
        exp_q.push_back({le, be, m_last});
    endtask

    task automatic idle(input int k, input logic [1:0] m);
        repeat (k) step(1'b0, 2'd0, 1'b0, m);
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if ({led, busy, last_index} !== e) begin
                    mismatched++;
                    $display("FAIL out t=%0t: got led=%b busy=%b last=%0d exp led=%b busy=%b last=%0d",
                             $time, led, busy, last_index, e[3], e[2], e[1:0]);
                end
            end
        end
    end

    initial begin : stim
        int r;
        logic [1:0] b;
        repeat (3) step(1'b1, 2'd0, 1'b0, 2'd0);
        idle(3, 2'd1);
        idle(3, 2'd0);
        step(1'b0, 2'd2, 1'b0, 2'd0);
        idle(20, 2'd0);
        step(1'b0, 2'd1, 1'b1, 2'd1);
        idle(20, 2'd1);
        step(1'b0, 2'd1, 1'b0, 2'd0);
        idle(5, 2'd0);
        step(1'b0, 2'd2, 1'b0, 2'd0);
        idle(20, 2'd0);
        step(1'b0, 2'd3, 1'b0, 2'd1);
        step(1'b0, 2'd3, 1'b1, 2'd1);
        idle(3, 2'd1);
        step(1'b0, 2'd1, 1'b0, 2'd0);
        idle(2, 2'd0);
        step(1'b0, 2'd3, 1'b1, 2'd0);
        idle(12, 2'd0);
        step(1'b0, 2'd2, 1'b0, 2'd0);
        idle(2, 2'd0);
        step(1'b1, 2'd1, 1'b1, 2'd1);
        idle(4, 2'd1);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            b = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 :
                (r == 2) ? 2'd3 : 2'd0;
            step(($urandom_range(0, 299) == 0),
                 b, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end
        idle(2, 2'd0);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
